// File: rtl/sipo_frame_receiver.sv
`default_nettype none
// sipo_frame_receiver: start/data/stop deframer that feeds a parallel load register.
// Define SIPO_PARITY_EN to add one even-parity bit between the data bits and the stop bit.
module sipo_frame_receiver #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample_en,
  input  logic             sdi,
  output logic [WIDTH-1:0] data_out,
  output logic             load,
  output logic             busy,
  output logic             frame_err,
  output logic             parity_err
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             load_q, load_d;
  logic             busy_q, busy_d;
  logic             ferr_q, ferr_d;

`ifdef SIPO_PARITY_EN
  logic par_q, par_d;
  logic perr_q, perr_d;
  logic par_ok;

  // Even parity: data bits XOR parity bit must be zero.
  assign par_ok = ~(^sh_q ^ par_q);
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    data_d  = data_q;
    load_d  = 1'b0;
    ferr_d  = 1'b0;
`ifdef SIPO_PARITY_EN
    par_d   = par_q;
    perr_d  = 1'b0;
`endif
    if (sample_en) begin
      case (state_q)
        IDLE: begin
          if (!sdi) begin
            state_d = DATA;
            cnt_d   = '0;
          end
        end
        DATA: begin
          sh_d  = {sdi, sh_q[WIDTH-1:1]};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
`ifdef SIPO_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
`ifdef SIPO_PARITY_EN
        PARITY: begin
          par_d   = sdi;
          state_d = STOP;
        end
`endif
        STOP: begin
          state_d = IDLE;
          // A bad stop bit outranks any parity result.
          if (!sdi) begin
            ferr_d = 1'b1;
          end
`ifdef SIPO_PARITY_EN
          else if (!par_ok) begin
            perr_d = 1'b1;
          end
`endif
          else begin
            load_d = 1'b1;
            data_d = sh_q;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      load_q  <= 1'b0;
      busy_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      load_q  <= load_d;
      busy_q  <= busy_d;
      ferr_q  <= ferr_d;
    end
  end

`ifdef SIPO_PARITY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      par_q  <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      par_q  <= par_d;
      perr_q <= perr_d;
    end
  end

  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

  assign data_out  = data_q;
  assign load      = load_q;
  assign busy      = busy_q;
  assign frame_err = ferr_q;

endmodule
`default_nettype wire

// File: tb/tb_sipo_frame_receiver.sv
`default_nettype none
// tb_sipo_frame_receiver: directed and random frames checked against a frame-level model.
module tb_sipo_frame_receiver;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             sample_en;
  logic             sdi;
  logic [WIDTH-1:0] data_out;
  logic             load;
  logic             busy;
  logic             frame_err;
  logic             parity_err;

  sipo_frame_receiver #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .sample_en  (sample_en),
    .sdi        (sdi),
    .data_out   (data_out),
    .load       (load),
    .busy       (busy),
    .frame_err  (frame_err),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  int load_cnt = 0, ferr_cnt = 0, perr_cnt = 0;
  int exp_load_cnt = 0, exp_ferr_cnt = 0, exp_perr_cnt = 0;
  logic [WIDTH-1:0] exp_data;
  logic [2:0]       prev_pulse = 3'b000;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse bookkeeping, exclusivity and single-cycle width, sampled mid-cycle.
  always @(negedge clk) begin
    if (load)       load_cnt++;
    if (frame_err)  ferr_cnt++;
    if (parity_err) perr_cnt++;
    if (load | frame_err | parity_err)
      check_eq("excl", 32'(load) + 32'(frame_err) + 32'(parity_err), 32'd1);
    if (prev_pulse != 3'b000)
      check_eq("pulse_len", 32'({load, frame_err, parity_err} & prev_pulse), 32'd0);
    prev_pulse = {load, frame_err, parity_err};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One bit time: gap-1 idle cycles with line noise, then a single-cycle strobe.
  task automatic strobe(input logic b, input int gap);
    repeat (gap - 1) tick();
    sample_en = 1'b1;
    sdi       = b;
    tick();
    sample_en = 1'b0;
    sdi       = 1'($urandom_range(1, 0));
  endtask

  task automatic check_counts(input string tag);
    check_eq({tag, "_loads"}, load_cnt, exp_load_cnt);
    check_eq({tag, "_ferrs"}, ferr_cnt, exp_ferr_cnt);
    check_eq({tag, "_perrs"}, perr_cnt, exp_perr_cnt);
  endtask

  task automatic send_frame(input logic [WIDTH-1:0] data, input logic stop,
                            input logic par_bit, input int gap);
    logic ok_par, e_l, e_f, e_p;
    strobe(1'b0, gap);
    check_eq("busy_start", busy, 1'b1);
    check_counts("prior");
    for (int i = 0; i < WIDTH; i++) strobe(data[i], gap);
`ifdef SIPO_PARITY_EN
    strobe(par_bit, gap);
    ok_par = ((^data) ^ par_bit) == 1'b0;
`else
    ok_par = 1'b1 | par_bit;
`endif
    strobe(stop, gap);
    e_l = 1'b0; e_f = 1'b0; e_p = 1'b0;
    if (!stop)        e_f = 1'b1;
    else if (!ok_par) e_p = 1'b1;
    else begin
      e_l      = 1'b1;
      exp_data = data;
    end
    exp_load_cnt += int'(e_l);
    exp_ferr_cnt += int'(e_f);
    exp_perr_cnt += int'(e_p);
    check_eq("load", load, e_l);
    check_eq("frame_err", frame_err, e_f);
    check_eq("parity_err", parity_err, e_p);
    check_eq("data_out", 32'(data_out), 32'(exp_data));
    check_eq("busy_end", busy, 1'b0);
  endtask

  function automatic logic good_par(input logic [WIDTH-1:0] d);
    return ^d;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset     = 1'b1;
    sample_en = 1'b0;
    sdi       = 1'b1;
    exp_data  = '0;
    tick();
    tick();
    check_eq("rst_data", 32'(data_out), 32'd0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_pulses", {load, frame_err, parity_err}, 3'b000);
    reset = 1'b0;

    for (int i = 0; i < 20; i++) begin
      strobe(1'b1, 1);
      check_eq("idle_busy", busy, 1'b0);
    end
    tick();
    check_eq("idle_data", 32'(data_out), 32'd0);
    check_counts("idle");

    send_frame(4'hA, 1'b1, good_par(4'hA), 1);
    send_frame(4'h3, 1'b1, good_par(4'h3), 4);
    send_frame(4'hC, 1'b1, good_par(4'hC), 4);
    send_frame(4'h5, 1'b0, good_par(4'h5), 2);
    send_frame(4'h9, 1'b1, good_par(4'h9), 1);
`ifdef SIPO_PARITY_EN
    send_frame(4'h7, 1'b1, 1'b0, 1);
    send_frame(4'h7, 1'b1, 1'b1, 1);
`endif

    // Abort a frame of 4'hF after its second data bit.
    strobe(1'b0, 1);
    strobe(1'b1, 1);
    strobe(1'b1, 1);
    reset = 1'b1;
    #1;
    check_eq("abort_data", 32'(data_out), 32'd0);
    check_eq("abort_busy", busy, 1'b0);
    exp_data = '0;
    tick();
    reset = 1'b0;
    repeat (10) tick();
    check_counts("abort");
    send_frame(4'h6, 1'b1, good_par(4'h6), 1);

    for (int n = 0; n < 40; n++) begin
      logic [WIDTH-1:0] d;
      logic             stp;
      logic             pb;
      int               gap;
      d   = WIDTH'($urandom);
      stp = ($urandom_range(7, 0) != 0);
      pb  = good_par(d) ^ ($urandom_range(3, 0) == 0);
      gap = int'($urandom_range(4, 1));
      repeat ($urandom_range(2, 0)) strobe(1'b1, gap);
      send_frame(d, stp, pb, gap);
    end

    repeat (3) tick();
    check_counts("final");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sipo_frame_receiver.md
# sipo_frame_receiver

Serial-to-parallel front end for the 4-bit parallel load register. It watches a single idle-high serial line, decodes start / data / (optional parity) / stop framing at a bit-rate strobe and assembles WIDTH data bits LSB-first. Each correctly framed word is presented on `data_out` with a one-cycle `load` pulse, so both outputs wire directly to the register's `data_in` and `load`. Framing and parity failures are flagged and never produce a `load`.

## Interface
- `WIDTH`, default 4: data bits per frame; legal range 2–16.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high.
- `sample_en`  in  1  bit-time strobe; `sdi` is sampled only on cycles where this is 1.
- `sdi`  in  1  serial line; idles high, synchronous to `clk`.
- `data_out`  out  WIDTH  last good word; held between frames.
- `load`  out  1  one-cycle pulse when `data_out` is updated.
- `busy`  out  1  1 whenever the FSM is not in IDLE.
- `frame_err`  out  1  one-cycle pulse when the stop bit is sampled 0.
- `parity_err`  out  1  one-cycle pulse on a parity mismatch; constant 0 when parity is compiled out.

## Operation
- State is held on any cycle where `sample_en` = 0; all transitions below require `sample_en` = 1.
- FSM states: IDLE, DATA, PARITY, STOP.
- IDLE: if `sdi` = 0, the start bit is accepted, the bit counter is cleared and the FSM goes to DATA. If `sdi` = 1, it stays in IDLE. The start bit is not re-validated.
- DATA: shift register updates as `sh <= {sdi, sh[WIDTH-1:1]}`, making the first data bit the LSB. The counter increments. At count WIDTH-1 the FSM goes to PARITY when parity is compiled in, otherwise to STOP.
- PARITY: the sampled bit is captured and the FSM goes to STOP.
- STOP, with `sdi` = 1 and parity OK (or parity compiled out): `data_out <= sh`, `load` pulses. Go to IDLE.
- STOP, with `sdi` = 1 and a parity mismatch: `parity_err` pulses, no `load`, `data_out` unchanged. Go to IDLE.
- STOP, with `sdi` = 0: `frame_err` pulses, no `load`, `data_out` unchanged. `parity_err` is suppressed because a frame error takes precedence. Go to IDLE.
- Back-to-back frames: the first `sample_en` after STOP is evaluated in IDLE, so a start bit can immediately follow a stop bit.
- Reset mid-frame aborts the frame. No `load` or error pulse is generated for the aborted frame.

## Timing
- Reset values: `data_out` = 0, `load` = 0, `busy` = 0, `frame_err` = 0, `parity_err` = 0. FSM = IDLE; counter and shift register = 0.
- All outputs are registered.
- `load`, `frame_err` and `parity_err` assert in the cycle after the `clk` edge that samples the stop bit, and last exactly one `clk` cycle.
- `data_out` takes its new value in the same cycle that `load` asserts.
- Frame length in strobes, start through stop: WIDTH+2, or WIDTH+3 with parity.
- `busy` rises the cycle after the start sample and falls the cycle after the stop sample, which is the same cycle as `load`.
- At most one of `load`, `frame_err`, `parity_err` is high in any cycle.
- `sample_en` may be asserted on consecutive cycles; the block has no minimum strobe spacing.

## Configuration
- `SIPO_PARITY_EN` defined:
  - PARITY state present.
  - One even-parity bit follows the data bits; the XOR of data and parity must be 0.
  - `parity_err` is live.
- `SIPO_PARITY_EN` undefined:
  - No PARITY state; the last data bit goes directly to STOP.
  - `parity_err` is tied to 0.

## Test plan
- Reset, then idle line (`sdi` = 1) with 20 `sample_en` strobes → `busy`, `load` and both error outputs stay 0, `data_out` = 4'h0.
- Frame 0,[0,1,0,1],(parity 0),1 with `sample_en` every cycle → `data_out` = 4'hA, `load` high for exactly one cycle, one cycle after the stop sample.
- Two back-to-back frames carrying 4'h3 then 4'hC, with `sample_en` asserted once every 4 clocks → two `load` pulses with values 3 then C. `data_out` holds 3 until the second pulse.
- Frame carrying 4'h5 with stop bit = 0 → `frame_err` pulse, no `load`, `data_out` keeps its prior value. A following valid frame carrying 4'h9 loads 9.
- With `SIPO_PARITY_EN` defined: frame carrying 4'h7 with parity bit 0 (wrong) → `parity_err` pulse, no `load`. The same frame with parity bit 1 → `load`, `data_out` = 4'h7.
- `reset` asserted after the 2nd data bit of a frame carrying 4'hF → all outputs return to 0 immediately and no `load` follows. The next full frame carrying 4'h6 loads 6.
